// File: rtl/fp32_mul_seq_if.sv
// Handshake and operand/result bundle for the sequential fp32 multiplier.
interface fp32_mul_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  round_mode;
  logic        busy;
  logic        done;
  logic [31:0] resultMul;
  logic        errorMul;
  logic        overflowMul;

  // Requester side: drives operands and start, observes status/result.
  modport master (
    output start, A, B, round_mode,
    input  busy, done, resultMul, errorMul, overflowMul
  );

  // Multiplier side.
  modport slave (
    input  start, A, B, round_mode,
    output busy, done, resultMul, errorMul, overflowMul
  );
endinterface

// File: rtl/fp32_mul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier with start/done handshake.
// Iterative shift-add mantissa multiply, flush-to-zero on subnormal in/out.
// Optional macro MUL_RADIX4_EN: consume two multiplier bits per MULT cycle
// (12 MULT cycles instead of 24); results are bit-identical.
module fp32_mul_seq (
  input logic           clk,
  input logic           reset,
  fp32_mul_seq_if.slave bus
);

  localparam int unsigned BIAS   = 127;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned ACC_W  = 2 * MANT_W;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned CNT_W  = 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MULT   = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

`ifdef MUL_RADIX4_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(11);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(23);
`endif

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // State and captured request
  logic [2:0]              r_state;
  logic [31:0]             r_a;
  logic [31:0]             r_b;
  logic [1:0]              r_rm;
  logic                    r_sign;

  // Multiply datapath
  logic [MANT_W-1:0]       r_ma;
  logic [MANT_W-1:0]       r_mb;
`ifdef MUL_RADIX4_EN
  logic [MANT_W+1:0]       r_mb3;
`endif
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_cnt;

  // Normalised intermediate
  logic signed [EXP_W-1:0] r_exp;
  logic [MANT_W-2:0]       r_mant;
  logic                    r_g;
  logic                    r_s;

  // Registered outputs
  logic                    r_busy;
  logic                    r_done;
  logic [31:0]             r_result;
  logic                    r_err;
  logic                    r_ovf;

  // Combinational helpers
  logic [2:0]              w_next_state;
  logic                    w_sign;
  logic [7:0]              w_a_exp;
  logic [7:0]              w_b_exp;
  logic                    w_a_nan;
  logic                    w_b_nan;
  logic                    w_a_inf;
  logic                    w_b_inf;
  logic                    w_a_zero;
  logic                    w_b_zero;
  logic                    w_special;
  logic [31:0]             w_sp_result;
  logic                    w_sp_err;
  logic [ACC_W-1:0]        w_addend;
  logic signed [EXP_W-1:0] w_exp_sum;
  logic signed [EXP_W-1:0] w_norm_exp;
  logic [MANT_W-2:0]       w_norm_mant;
  logic                    w_norm_g;
  logic                    w_norm_s;
  logic                    w_inc;
  logic [MANT_W-1:0]       w_mant_rnd;
  logic signed [EXP_W-1:0] w_exp_rnd;
  logic [31:0]             w_rnd_result;
  logic                    w_rnd_ovf;

  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_a_exp  = r_a[30:23];
  assign w_b_exp  = r_b[30:23];
  assign w_a_nan  = (w_a_exp == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan  = (w_b_exp == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_a_inf  = (w_a_exp == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (w_b_exp == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_zero = (w_a_exp == 8'h00);
  assign w_b_zero = (w_b_exp == 8'h00);

  // Special-operand classification; subnormals count as zero
  always_comb begin
    w_special   = 1'b1;
    w_sp_result = {w_sign, 31'd0};
    w_sp_err    = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
      w_sp_result = QNAN;
      w_sp_err    = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_sp_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_sp_result = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // Partial product for the current MULT step
`ifdef MUL_RADIX4_EN
  always_comb begin
    w_addend = '0;
    case (r_ma[1:0])
      2'd1:    w_addend = ACC_W'(r_mb);
      2'd2:    w_addend = ACC_W'(r_mb) << 1;
      2'd3:    w_addend = ACC_W'(r_mb3);
      default: w_addend = '0;
    endcase
    w_addend = w_addend << {r_cnt, 1'b0};
  end
`else
  always_comb begin
    w_addend = '0;
    if (r_ma[0]) begin
      w_addend = ACC_W'(r_mb) << r_cnt;
    end
  end
`endif

  // Normalise the 48-bit product and extract guard/sticky
  always_comb begin
    w_exp_sum = EXP_W'(w_a_exp) + EXP_W'(w_b_exp) - EXP_W'(BIAS);
    if (r_acc[ACC_W-1]) begin
      w_norm_mant = r_acc[46:24];
      w_norm_g    = r_acc[23];
      w_norm_s    = |r_acc[22:0];
      w_norm_exp  = w_exp_sum + 10'sd1;
    end else begin
      w_norm_mant = r_acc[45:23];
      w_norm_g    = r_acc[22];
      w_norm_s    = |r_acc[21:0];
      w_norm_exp  = w_exp_sum;
    end
  end

  // Rounding increment, carry into exponent, and range packing
  always_comb begin
    case (r_rm)
      2'b00:   w_inc = (r_g | r_s) & ~r_sign;
      2'b01:   w_inc = (r_g | r_s) & r_sign;
      2'b10:   w_inc = r_g & (r_s | r_mant[0]);
      default: w_inc = r_g;
    endcase
    w_mant_rnd = {1'b0, r_mant} + MANT_W'(w_inc);
    w_exp_rnd  = r_exp + (w_mant_rnd[MANT_W-1] ? 10'sd1 : 10'sd0);
    w_rnd_ovf  = 1'b0;
    if (w_exp_rnd >= 10'sd255) begin
      w_rnd_result = {r_sign, 8'hFF, 23'd0};
      w_rnd_ovf    = 1'b1;
    end else if (w_exp_rnd <= 10'sd0) begin
      w_rnd_result = {r_sign, 31'd0};
    end else begin
      w_rnd_result = {r_sign, w_exp_rnd[7:0], w_mant_rnd[MANT_W-2:0]};
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next_state = S_UNPACK;
      S_UNPACK: w_next_state = w_special ? S_DONE : S_MULT;
      S_MULT:   if (r_cnt == LAST_CNT) w_next_state = S_NORM;
      S_NORM:   w_next_state = S_ROUND;
      S_ROUND:  w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_rm     <= '0;
      r_sign   <= 1'b0;
      r_ma     <= '0;
      r_mb     <= '0;
`ifdef MUL_RADIX4_EN
      r_mb3    <= '0;
`endif
      r_acc    <= '0;
      r_cnt    <= '0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_g      <= 1'b0;
      r_s      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_rm  <= bus.round_mode;
            r_err <= 1'b0;
            r_ovf <= 1'b0;
          end
        end
        S_UNPACK: begin
          r_sign <= w_sign;
          if (w_special) begin
            r_result <= w_sp_result;
            r_err    <= w_sp_err;
            r_ovf    <= 1'b0;
          end else begin
            r_ma  <= {1'b1, r_a[22:0]};
            r_mb  <= {1'b1, r_b[22:0]};
`ifdef MUL_RADIX4_EN
            r_mb3 <= (MANT_W+2)'({1'b1, r_b[22:0]}) + ((MANT_W+2)'({1'b1, r_b[22:0]}) << 1);
`endif
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_MULT: begin
          r_acc <= r_acc + w_addend;
`ifdef MUL_RADIX4_EN
          r_ma  <= r_ma >> 2;
`else
          r_ma  <= r_ma >> 1;
`endif
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_NORM: begin
          r_exp  <= w_norm_exp;
          r_mant <= w_norm_mant;
          r_g    <= w_norm_g;
          r_s    <= w_norm_s;
        end
        S_ROUND: begin
          r_result <= w_rnd_result;
          r_ovf    <= w_rnd_ovf;
          r_err    <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.resultMul   = r_result;
  assign bus.errorMul    = r_err;
  assign bus.overflowMul = r_ovf;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench for fp32_mul_seq: directed vector table, start-ignore
// and mid-operation reset sequences, and randomized operands against a
// plain-arithmetic reference model.
module tb_fp32_mul_seq;

`ifdef MUL_RADIX4_EN
  localparam int FIN_LAT = 15;
`else
  localparam int FIN_LAT = 27;
`endif
  localparam int MAX_WAIT = 100;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fp32_mul_seq_if u_if ();

  fp32_mul_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] res;
    logic        err;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, then round by comparing the discarded
  // remainder against half an ulp.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] rm, output logic [31:0] r,
                                  output logic e, output logic o, output int lat);
    int ea, eb, ex;
    longint unsigned sa, sb, p, sig, rem, half;
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inc;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    e = 1'b0;
    o = 1'b0;
    lat = 1;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      r = 32'h7FC00000;
      e = 1'b1;
      return;
    end
    if (a_inf || b_inf) begin
      r = {s, 8'hFF, 23'd0};
      return;
    end
    if (a_zero || b_zero) begin
      r = {s, 31'd0};
      return;
    end
    lat = FIN_LAT;
    sa = (64'd1 << 23) + 64'(a[22:0]);
    sb = (64'd1 << 23) + 64'(b[22:0]);
    p  = sa * sb;
    ex = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sig  = p >> 24;
      rem  = p % (64'd1 << 24);
      half = 64'd1 << 23;
      ex   = ex + 1;
    end else begin
      sig  = p >> 23;
      rem  = p % (64'd1 << 23);
      half = 64'd1 << 22;
    end
    case (rm)
      2'b00:   inc = (rem != 0) && !s;
      2'b01:   inc = (rem != 0) && s;
      2'b10:   inc = (rem > half) || ((rem == half) && sig[0]);
      default: inc = (rem >= half);
    endcase
    sig = sig + 64'(inc);
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      ex  = ex + 1;
    end
    if (ex >= 255) begin
      r = {s, 8'hFF, 23'd0};
      o = 1'b1;
    end else if (ex <= 0) begin
      r = {s, 31'd0};
    end else begin
      r = {s, 8'(ex), 23'(sig)};
    end
  endfunction

  // One operation; optionally pulses start with other operands at sample inj_cyc.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        input int inj_cyc, input logic [31:0] inj_a, input logic [31:0] inj_b,
                        output logic [31:0] res, output logic err, output logic ovf,
                        output int lat, output logic busy_ok, output logic pulse_ok);
    @(negedge clk);
    u_if.A          = a;
    u_if.B          = b;
    u_if.round_mode = rm;
    u_if.start      = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == inj_cyc) begin
        u_if.A          = inj_a;
        u_if.B          = inj_b;
        u_if.round_mode = 2'b11;
        u_if.start      = 1'b1;
      end else begin
        u_if.start = 1'b0;
      end
      if (!u_if.busy) busy_ok = 1'b0;
      if (u_if.done) break;
    end
    res = u_if.resultMul;
    err = u_if.errorMul;
    ovf = u_if.overflowMul;
    u_if.start = 1'b0;
    @(posedge clk);
    #1;
    pulse_ok = !u_if.done && !u_if.busy;
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rm, input logic [31:0] e_res, input logic e_err,
                          input logic e_ovf, input int e_lat);
    logic [31:0] res;
    logic err, ovf, busy_ok, pulse_ok;
    int lat;
    run_op(a, b, rm, 0, 32'd0, 32'd0, res, err, ovf, lat, busy_ok, pulse_ok);
    check({tag, " result"}, res, e_res);
    check({tag, " errorMul"}, 32'(err), 32'(e_err));
    check({tag, " overflowMul"}, 32'(ovf), 32'(e_ovf));
    check({tag, " latency"}, 32'(lat), 32'(e_lat));
    check({tag, " busy/pulse"}, {30'd0, busy_ok, pulse_ok}, 32'd3);
  endtask

  function automatic logic [31:0] gen_operand();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 6) begin
      r[30:23] = 8'($urandom_range(64, 190));
    end else if (sel == 6) begin
      r[30:23] = 8'($urandom_range(1, 254));
    end else if (sel == 7) begin
      r[30:23] = 8'($urandom_range(100, 150));
      r[22:0]  = 23'h7FFFFF - 23'($urandom_range(0, 3));
    end else if (sel == 8) begin
      case ($urandom_range(0, 3))
        0:       r[30:23] = 8'd0;
        1:       r[30:23] = 8'd1;
        2:       r[30:23] = 8'd254;
        default: r[30:23] = 8'd255;
      endcase
      if ($urandom_range(0, 1) == 0) r[22:0] = 23'd0;
    end
    return r;
  endfunction

  vec_t tv[12];

  initial begin
    logic [31:0] res, ra, rb, e_res;
    logic err, ovf, busy_ok, pulse_ok, e_err, e_ovf;
    logic [1:0] rm;
    int lat, e_lat;
    logic seen_done;

    total = 0;
    bad   = 0;

    tv[0]  = '{32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, 1'b0, 1'b0, FIN_LAT};
    tv[1]  = '{32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800002, 1'b0, 1'b0, FIN_LAT};
    tv[2]  = '{32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800003, 1'b0, 1'b0, FIN_LAT};
    tv[3]  = '{32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 1'b0, 1'b0, FIN_LAT};
    tv[4]  = '{32'hBF800001, 32'h3F800001, 2'b01, 32'hBF800003, 1'b0, 1'b0, FIN_LAT};
    tv[5]  = '{32'h7F000000, 32'h40000000, 2'b10, 32'h7F800000, 1'b0, 1'b1, FIN_LAT};
    tv[6]  = '{32'h00800000, 32'hBF000000, 2'b10, 32'h80000000, 1'b0, 1'b0, FIN_LAT};
    tv[7]  = '{32'h00000000, 32'h7F800000, 2'b10, 32'h7FC00000, 1'b1, 1'b0, 1};
    tv[8]  = '{32'h7F800000, 32'hC0000000, 2'b10, 32'hFF800000, 1'b0, 1'b0, 1};
    tv[9]  = '{32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 1'b1, 1'b0, 1};
    tv[10] = '{32'h80000000, 32'h3F800000, 2'b11, 32'h80000000, 1'b0, 1'b0, 1};
    tv[11] = '{32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800002, 1'b0, 1'b0, FIN_LAT};

    u_if.start      = 1'b0;
    u_if.A          = '0;
    u_if.B          = '0;
    u_if.round_mode = '0;
    reset           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {27'd0, u_if.busy, u_if.done, u_if.errorMul, u_if.overflowMul, 1'b0}, 32'd0);
    check("reset result", u_if.resultMul, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      check_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].rm,
               tv[i].res, tv[i].err, tv[i].ovf, tv[i].lat);
    end

    // start pulsed mid-operation is ignored
    run_op(32'h40000000, 32'h40400000, 2'b10, 5, 32'h7F800000, 32'h00000000,
           res, err, ovf, lat, busy_ok, pulse_ok);
    check("ignore-start result", res, 32'h40C00000);
    check("ignore-start flags", {30'd0, err, ovf}, 32'd0);
    check("ignore-start latency", 32'(lat), 32'(FIN_LAT));

    // Reset mid-operation discards it
    @(negedge clk);
    u_if.A          = 32'h7F000000;
    u_if.B          = 32'h40000000;
    u_if.round_mode = 2'b10;
    u_if.start      = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid-reset outputs", {28'd0, u_if.busy, u_if.done, u_if.errorMul, u_if.overflowMul}, 32'd0);
    check("mid-reset result", u_if.resultMul, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (FIN_LAT + 5) begin
      @(posedge clk);
      #1;
      if (u_if.done || u_if.busy) seen_done = 1'b1;
    end
    check("no done after reset", 32'(seen_done), 32'd0);
    check_op("post-reset", 32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, 1'b0, 1'b0, FIN_LAT);

    // Randomized operands against the reference model
    for (int n = 0; n < 150; n++) begin
      ra = gen_operand();
      rb = gen_operand();
      rm = 2'($urandom_range(0, 3));
      ref_mul(ra, rb, rm, e_res, e_err, e_ovf, e_lat);
      run_op(ra, rb, rm, 0, 32'd0, 32'd0, res, err, ovf, lat, busy_ok, pulse_ok);
      if (res !== e_res || err !== e_err || ovf !== e_ovf || lat != e_lat) begin
        $display("FAIL rand%0d: A=%08h B=%08h rm=%0d got %08h/%0b/%0b lat %0d expected %08h/%0b/%0b lat %0d",
                 n, ra, rb, rm, res, err, ovf, lat, e_res, e_err, e_ovf, e_lat);
        bad++;
      end
      total++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp32_mul_seq.md
Name: fp32_mul_seq

Overview:
- Multi-cycle IEEE-754 single-precision multiplier; the inverse-operation companion of the FPU's combinational divider.
- Iterative shift-add mantissa multiply with a start/done handshake.
- Uses the same 2-bit rounding-mode encoding and the same error/overflow flag semantics as the rest of the FPU datapath.

Parameters:
- BIAS, 127, exponent bias
- MANT_W, 24, significand width including hidden bit

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- A  in  32  operand, captured on accepted start
- B  in  32  operand, captured on accepted start
- round_mode  in  2  00 toward +inf, 01 toward -inf, 10 nearest-even, 11 nearest ties-away; captured on accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, result valid
- resultMul  out  32  product
- errorMul  out  1  invalid operation
- overflowMul  out  1  finite result overflowed to infinity

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, resultMul=0, errorMul=0, overflowMul=0; iteration counter and accumulator cleared. An in-flight operation is discarded.
- States: IDLE, UNPACK, MULT, NORM, ROUND, DONE.
- IDLE: start=1 at edge k captures A, B and round_mode, then goes to UNPACK. start in any other state is ignored, with no queueing.
- UNPACK, edge k+1, sign = A[31]^B[31]. Special cases go straight to DONE:
  - Either operand NaN, or 0 times inf: result 0x7FC00000, errorMul=1.
  - inf times nonzero: {sign, 0xFF, 0}, overflowMul=0.
  - Either operand zero or subnormal (E=0), flushed: {sign, 31'b0}.
  - Otherwise the block loads mantissas {1,F}, clears the 48-bit accumulator and counter, and goes to MULT.
- MULT: one multiplier bit per cycle, LSB first. If the bit is set, add the multiplicand shifted by the counter. 24 cycles; on counter=23 go to NORM.
- NORM: 10-bit signed exponent e = Ea + Eb - BIAS.
  - P[47]=1: mantissa P[46:24], G=P[23], S=|P[22:0], e+1.
  - P[47]=0: mantissa P[45:23], G=P[22], S=|P[21:0].
- ROUND: increment when the condition for the mode holds (L = mantissa LSB):
  - 10: G&(S|L)
  - 11: G
  - 00: (G|S)&~sign
  - 01: (G|S)&sign
  - A carry out of the mantissa sets mantissa=0 and adds 1 to e.
  - e>=255: {sign, 0xFF, 0}, overflowMul=1.
  - e<=0: {sign, 31'b0}, flags 0, no subnormal output.
  - Otherwise {sign, e[7:0], mantissa}.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge.
- Latency from the accepting edge k: finite operands have DONE entered at edge k+27; special cases at edge k+1.
- resultMul and the flags update only on entry to DONE. They hold until the next DONE or reset. Both flags clear on every accepted start.

Optional Feature:
- Macro MUL_RADIX4_EN.
- Defined: MULT consumes two multiplier bits per cycle, adding 0, 1x, 2x or 3x the multiplicand; 3x is precomputed in UNPACK. MULT takes 12 cycles and finite latency is 15. Results are bit-identical.
- Undefined: radix-2, 24 MULT cycles, latency 27.

Test Plan:
- 0x40000000 × 0x40400000, mode 10: resultMul=0x40C00000, flags 0, done exactly 27 cycles after start (15 with MUL_RADIX4_EN), busy high throughout.
- 0x3F800001 × 0x3F800001:
  - Mode 10 gives 0x3F800002.
  - Mode 00 gives 0x3F800003.
  - Mode 01 gives 0x3F800002.
  - Negating one operand (0xBF800001) in mode 01 gives 0xBF800003.
- 0x7F000000 × 0x40000000: resultMul=0x7F800000, overflowMul=1. 0x00800000 × 0xBF000000: resultMul=0x80000000, flags 0.
- 0x00000000 × 0x7F800000: resultMul=0x7FC00000, errorMul=1, done one cycle after start. 0x7F800000 × 0xC0000000: resultMul=0xFF800000, overflowMul=0.
- Pulse start with new operands 5 cycles into an operation: ignored, the first result is unchanged.
- Assert reset 10 cycles into an operation: all outputs 0 immediately, no done pulse; a new start afterwards completes normally.
